// File: rtl/updown_counter_param_pkg.sv
//------------------------------------------------------------------------------
// updown_counter_param_pkg
//   Shared mode and direction encodings for the up/down counter family.
//------------------------------------------------------------------------------
`default_nettype none

package updown_counter_param_pkg;

  // Limit behaviour selected by SAT_MODE
  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Direction encoding carried on up_dn
  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

endpackage : updown_counter_param_pkg

`default_nettype wire

// File: rtl/updown_counter_param_cnt_next_val.sv
//------------------------------------------------------------------------------
// cnt_next_val
//   Combinational next-count and limit-event logic for updown_counter_param.
//   wrap_evt flags an enabled step at a limit (it becomes the top-level tc).
//------------------------------------------------------------------------------
`default_nettype none

module cnt_next_val
  import updown_counter_param_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = (2**WIDTH)-1,
  parameter int SAT_MODE = CNT_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap_evt,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  // An out-of-range limit cannot be represented in the count register
  if (MAX_VAL > (2**WIDTH)-1) begin : g_max_val_illegal
    $error("cnt_next_val: MAX_VAL exceeds 2**WIDTH-1");
  end

  logic [WIDTH-1:0] load_clamped;
  logic             going_up;

  // Limit decodes, load clamping and the limit event
  always_comb begin
    at_max       = (count == MAX_V);
    at_zero      = (count == '0);
    going_up     = (up_dn == CNT_UP);
    // Widened compare keeps the clamp meaningful for any MAX_VAL
    load_clamped = (int'(load_val) > MAX_VAL) ? MAX_V : load_val;
    wrap_evt     = en & ~load & ((going_up & at_max) | (~going_up & at_zero));
  end

  // Next-count selection: load beats enable, enable beats hold
  always_comb begin
    next_count = count;
    if (load) begin
      next_count = load_clamped;
    end else if (en) begin
      if (going_up) begin
        if (!at_max) begin
          next_count = count + ONE;
        end else if (SAT_MODE == CNT_WRAP) begin
          next_count = '0;
        end
      end else begin
        if (!at_zero) begin
          next_count = count - ONE;
        end else if (SAT_MODE == CNT_WRAP) begin
          next_count = MAX_V;
        end
      end
    end
  end

endmodule : cnt_next_val

`default_nettype wire

// File: rtl/updown_counter_param.sv
//------------------------------------------------------------------------------
// updown_counter_param
//   Parametrised synchronous up/down counter with load, enable, modulus,
//   wrap/saturate selection, terminal-count output and sticky overflow flag.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module updown_counter_param
  import updown_counter_param_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = (2**WIDTH)-1,
  parameter int SAT_MODE = CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_zero,
  output logic             ovf
);

  logic [WIDTH-1:0] next_count;
  logic             wrap_evt;

  cnt_next_val #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SAT_MODE (SAT_MODE)
  ) u_next (
    .count      (count),
    .up_dn      (up_dn),
    .en         (en),
    .load       (load),
    .load_val   (load_val),
    .next_count (next_count),
    .wrap_evt   (wrap_evt),
    .at_max     (at_max),
    .at_zero    (at_zero)
  );

  // tc doubles as the enable of a cascaded next stage
  assign tc = wrap_evt;

  // Count register and sticky overflow; a limit event outranks a clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      count <= next_count;
      if (wrap_evt) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule : updown_counter_param

`default_nettype wire
